cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Synthesisable run controller that sequences a CPU test run: holds the CPU in reset for a parametrised number of cycles, releases it, counts cycles and retired instructions, and ends the run on halt detection or cycle-budget timeout.
- Replaces fixed-delay reset pulses and fixed-time end-of-run in benches with a deterministic, parametrised sequencer.
- Sits between the top-level clock/reset and the CPU's reset input. Its status outputs feed the bench and any on-chip debug logic.

Parameters:
- PC_WIDTH, 32, width of monitored program counter
- CNT_WIDTH, 16, width of cycle and instruction counters
- RST_CYCLES, 2, cycles cpu_reset_n is held low after start (must be ≥1)
- MAX_CYCLES, 100, run-phase cycle budget before timeout (must be ≥1 and <2^CNT_WIDTH)
- HALT_REPEAT, 3, consecutive retirements at an unchanged PC that declare halt (must be ≥2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low block reset
- start  in  1  one-cycle pulse; begins a run from IDLE, HALTED or TIMEOUT
- pc  in  PC_WIDTH  CPU program counter of the retiring instruction
- pc_valid  in  1  an instruction retires this cycle; pc is valid
- cpu_reset_n  out  1  active-low reset to CPU
- running  out  1  high in RUN state
- done  out  1  high in HALTED state
- timeout  out  1  high in TIMEOUT state
- cycle_count  out  CNT_WIDTH  cycles spent in RUN
- instr_count  out  CNT_WIDTH  pc_valid pulses seen in RUN, saturating
- halt_pc  out  PC_WIDTH  PC at which halt was detected

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; cpu_reset_n=0; running=0; done=0; timeout=0.
  - All counters, halt_pc and internal last_pc/repeat counter are cleared to 0.
  - Reset mid-run aborts immediately. No state survives.
- States: IDLE, RSTHOLD, RUN, HALTED, TIMEOUT. All outputs are registered (Moore).
- IDLE: cpu_reset_n=0. On start go to RSTHOLD.
- RSTHOLD:
  - cpu_reset_n=0.
  - The hold counter loads RST_CYCLES-1 on entry and decrements each cycle. Exit to RUN on the cycle the counter is 0.
  - cpu_reset_n is low for exactly RST_CYCLES cycles.
  - On entry, clear cycle_count, instr_count, halt_pc and the repeat tracker.
  - start in this state is ignored.
- RUN:
  - cpu_reset_n=1; running=1; cycle_count increments every cycle in RUN.
  - On pc_valid: instr_count increments (saturating at all-ones).
  - On pc_valid with pc==last_pc, repeat increments (saturating at HALT_REPEAT). Otherwise repeat=1 and last_pc=pc.
  - The first pc_valid after entry always sets repeat=1.
  - Halt condition: pc_valid, pc==last_pc and repeat==HALT_REPEAT-1. Next state is HALTED and halt_pc=pc.
  - Timeout condition: cycle_count==MAX_CYCLES-1 in this cycle (i.e. the MAX_CYCLES-th RUN cycle). Next state is TIMEOUT.
  - Simultaneous halt and timeout: halt wins; go to HALTED.
  - start in RUN is ignored.
- HALTED / TIMEOUT:
  - cpu_reset_n=0 (CPU frozen); done or timeout=1 respectively.
  - Counters and halt_pc hold their values.
  - start → RSTHOLD (restart). Counters clear on RSTHOLD entry, so prior results remain visible until restart.
- cycle_count cannot wrap, since MAX_CYCLES < 2^CNT_WIDTH. instr_count saturates.
- pc_valid outside RUN is ignored.

Test Plan:
- Hold reset=0 for 3 cycles, then release with no start → cpu_reset_n=0, all status outputs 0, counters 0, state stays IDLE.
- Pulse start with RST_CYCLES=2 → cpu_reset_n low exactly 2 cycles after start registers, then 1; running=1 from the same edge.
- In RUN, drive pc_valid each cycle with pc=0x00, 0x04, 0x08, 0x08, 0x08 (HALT_REPEAT=3) → done=1 the cycle after the third 0x08; halt_pc=0x08; instr_count=5; cpu_reset_n=0.
- MAX_CYCLES=100 with pc incrementing by 4 each cycle → timeout=1 after 100 RUN cycles; cycle_count=100; done=0.
- Force the halt condition on RUN cycle 100 → done=1, timeout=0.
- After TIMEOUT, pulse start → counters clear, new RSTHOLD of 2 cycles, running again. Also assert reset=0 mid-RUN → outputs return to reset values asynchronously before the next clk edge.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_run_ctrl_if : run-control bus between a test sequencer and CPU.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface cpu_run_ctrl_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic [PC_WIDTH-1:0]  pc;
  logic                 pc_valid;
  logic                 cpu_reset_n;
  logic                 running;
  logic                 done;
  logic                 timeout;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] instr_count;
  logic [PC_WIDTH-1:0]  halt_pc;

  modport master (
    output start, pc, pc_valid,
    input  cpu_reset_n, running, done, timeout, cycle_count, instr_count, halt_pc
  );

  modport slave (
    input  start, pc, pc_valid,
    output cpu_reset_n, running, done, timeout, cycle_count, instr_count, halt_pc
  );
endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_run_ctrl : sequences a CPU run (reset hold, run, halt/timeout).   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cpu_run_ctrl #(
  parameter int PC_WIDTH    = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 100,
  parameter int HALT_REPEAT = 3
) (
  input  wire logic       clk,
  input  wire logic       reset,
  cpu_run_ctrl_if.slave   bus
);

  localparam int c_HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int c_REP_W  = $clog2(HALT_REPEAT + 1);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_RSTHOLD = 3'd1;
  localparam logic [2:0] c_ST_RUN     = 3'd2;
  localparam logic [2:0] c_ST_HALTED  = 3'd3;
  localparam logic [2:0] c_ST_TIMEOUT = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [c_HOLD_W-1:0]  r_hold;
  logic [CNT_WIDTH-1:0] r_cycle;
  logic [CNT_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0]  r_halt_pc;
  logic [PC_WIDTH-1:0]  r_last_pc;
  logic [c_REP_W-1:0]   r_rep;
  logic                 r_cpu_reset_n;
  logic                 r_running;
  logic                 r_done;
  logic                 r_timeout;
  logic                 w_same_pc;
  logic                 w_halt;
  logic                 w_tmo;
  logic                 w_enter_hold;
  logic                 w_cpu_reset_n_nxt;
  logic                 w_running_nxt;
  logic                 w_done_nxt;
  logic                 w_timeout_nxt;

  // r_rep == 0 means no PC tracked yet, so the first retirement never matches
  assign w_same_pc    = (r_rep != '0) && (bus.pc == r_last_pc);
  assign w_halt       = bus.pc_valid && w_same_pc && (r_rep == c_REP_W'(HALT_REPEAT - 1));
  assign w_tmo        = (r_cycle == CNT_WIDTH'(MAX_CYCLES - 1));
  assign w_enter_hold = (r_state != c_ST_RSTHOLD) && (w_state_nxt == c_ST_RSTHOLD);

  // State register plus Moore outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_ST_IDLE;
      r_cpu_reset_n <= 1'b0;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cpu_reset_n <= w_cpu_reset_n_nxt;
      r_running     <= w_running_nxt;
      r_done        <= w_done_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (bus.start) w_state_nxt = c_ST_RSTHOLD;
      c_ST_RSTHOLD: if (r_hold == '0) w_state_nxt = c_ST_RUN;
      c_ST_RUN: begin
        // halt takes priority when both end conditions coincide
        if (w_halt)     w_state_nxt = c_ST_HALTED;
        else if (w_tmo) w_state_nxt = c_ST_TIMEOUT;
      end
      c_ST_HALTED,
      c_ST_TIMEOUT: if (bus.start) w_state_nxt = c_ST_RSTHOLD;
      default:      w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_cpu_reset_n_nxt = 1'b0;
    w_running_nxt     = 1'b0;
    w_done_nxt        = 1'b0;
    w_timeout_nxt     = 1'b0;
    case (w_state_nxt)
      c_ST_RUN: begin
        w_cpu_reset_n_nxt = 1'b1;
        w_running_nxt     = 1'b1;
      end
      c_ST_HALTED:  w_done_nxt    = 1'b1;
      c_ST_TIMEOUT: w_timeout_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold    <= '0;
      r_cycle   <= '0;
      r_instr   <= '0;
      r_halt_pc <= '0;
      r_last_pc <= '0;
      r_rep     <= '0;
    end else if (w_enter_hold) begin
      // results from the previous run stay visible until this point
      r_hold    <= c_HOLD_W'(RST_CYCLES - 1);
      r_cycle   <= '0;
      r_instr   <= '0;
      r_halt_pc <= '0;
      r_last_pc <= '0;
      r_rep     <= '0;
    end else if (r_state == c_ST_RSTHOLD) begin
      if (r_hold != '0) r_hold <= r_hold - c_HOLD_W'(1);
    end else if (r_state == c_ST_RUN) begin
      r_cycle <= r_cycle + CNT_WIDTH'(1);
      if (bus.pc_valid) begin
        if (r_instr != '1) r_instr <= r_instr + CNT_WIDTH'(1);
        if (w_same_pc) begin
          if (r_rep != c_REP_W'(HALT_REPEAT)) r_rep <= r_rep + c_REP_W'(1);
        end else begin
          r_rep     <= c_REP_W'(1);
          r_last_pc <= bus.pc;
        end
        if (w_halt) r_halt_pc <= bus.pc;
      end
    end
  end

  assign bus.cpu_reset_n = r_cpu_reset_n;
  assign bus.running     = r_running;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.cycle_count = r_cycle;
  assign bus.instr_count = r_instr;
  assign bus.halt_pc     = r_halt_pc;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cpu_run_ctrl : directed self-checking bench with end-of-run board. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_cpu_run_ctrl;

  localparam int c_PCW = 32;
  localparam int c_CW  = 16;

  typedef struct {
    string       tag;
    logic        done;
    logic        timeout;
    logic [15:0] cyc;
    logic [15:0] instr;
    logic [31:0] hpc;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  cpu_run_ctrl_if #(.PC_WIDTH(c_PCW), .CNT_WIDTH(c_CW)) bus ();

  cpu_run_ctrl #(
    .PC_WIDTH(c_PCW), .CNT_WIDTH(c_CW), .RST_CYCLES(2), .MAX_CYCLES(100), .HALT_REPEAT(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic crn, input logic run,
                            input logic dn, input logic to);
    check({tag, ".cpu_reset_n"}, 64'(bus.cpu_reset_n), 64'(crn));
    check({tag, ".running"},     64'(bus.running),     64'(run));
    check({tag, ".done"},        64'(bus.done),        64'(dn));
    check({tag, ".timeout"},     64'(bus.timeout),     64'(to));
  endtask

  task automatic sb_push(input string tag, input logic dn, input logic to,
                         input logic [15:0] cyc, input logic [15:0] ins, input logic [31:0] hpc);
    exp_t e;
    e.tag = tag; e.done = dn; e.timeout = to; e.cyc = cyc; e.instr = ins; e.hpc = hpc;
    sb.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    check("sb.nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".done"},        64'(bus.done),        64'(e.done));
      check({e.tag, ".timeout"},     64'(bus.timeout),     64'(e.timeout));
      check({e.tag, ".cpu_reset_n"}, 64'(bus.cpu_reset_n), 64'd0);
      check({e.tag, ".cycle_count"}, 64'(bus.cycle_count), 64'(e.cyc));
      check({e.tag, ".instr_count"}, 64'(bus.instr_count), 64'(e.instr));
      check({e.tag, ".halt_pc"},     64'(bus.halt_pc),     64'(e.hpc));
    end
  endtask

  // Pulse start, verify counter clear and a two-cycle CPU reset hold, end in RUN
  task automatic restart(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_outs({tag, ".hold1"}, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, ".clr_cycle"}, 64'(bus.cycle_count), 64'd0);
    check({tag, ".clr_instr"}, 64'(bus.instr_count), 64'd0);
    check({tag, ".clr_halt_pc"}, 64'(bus.halt_pc), 64'd0);
    tick();
    check_outs({tag, ".hold2"}, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs({tag, ".run"}, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] seq [0:4];
    logic [31:0] pcv;
    int          n;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.pc = '0;
    bus.pc_valid = 1'b0;
    seq[0] = 32'h00; seq[1] = 32'h04; seq[2] = 32'h08; seq[3] = 32'h08; seq[4] = 32'h08;

    // Reset and idle
    repeat (3) tick();
    check_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.cycle", 64'(bus.cycle_count), 64'd0);
    check("rst.instr", 64'(bus.instr_count), 64'd0);
    check("rst.halt_pc", 64'(bus.halt_pc), 64'd0);
    reset = 1'b1;
    bus.pc_valid = 1'b1;
    repeat (2) tick();
    bus.pc_valid = 1'b0;
    check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle.instr", 64'(bus.instr_count), 64'd0);

    // Halt after three retirements at 0x08
    restart("start1");
    sb_push("halt", 1'b1, 1'b0, 16'd5, 16'd5, 32'h08);
    for (int i = 0; i < 5; i++) begin
      bus.pc = seq[i];
      bus.pc_valid = 1'b1;
      if (i == 4) check("halt.pre_done", 64'(bus.done), 64'd0);
      tick();
    end
    bus.pc_valid = 1'b0;
    sb_pop();

    // HALTED holds results; retirements and start-free cycles change nothing
    bus.pc = 32'h44;
    bus.pc_valid = 1'b1;
    repeat (3) tick();
    bus.pc_valid = 1'b0;
    check_outs("halted.hold", 1'b0, 1'b0, 1'b1, 1'b0);
    check("halted.instr", 64'(bus.instr_count), 64'd5);

    // Timeout after 100 RUN cycles with an ever-changing PC
    restart("start2");
    sb_push("tmo", 1'b0, 1'b1, 16'd100, 16'd100, 32'h0);
    pcv = 32'h100;
    n = 0;
    while (!(bus.done || bus.timeout) && n < 200) begin
      bus.pc = pcv;
      bus.pc_valid = 1'b1;
      tick();
      pcv += 32'd4;
      n++;
    end
    bus.pc_valid = 1'b0;
    check("tmo.run_cycles", 64'(n), 64'd100);
    sb_pop();

    // Halt condition on the 100th RUN cycle beats the timeout
    restart("start3");
    sb_push("halt100", 1'b1, 1'b0, 16'd100, 16'd100, 32'hBEEF0);
    n = 0;
    while (!(bus.done || bus.timeout) && n < 200) begin
      n++;
      bus.pc = (n >= 98) ? 32'hBEEF0 : 32'h1000 + 32'(4 * n);
      bus.pc_valid = 1'b1;
      tick();
    end
    bus.pc_valid = 1'b0;
    check("halt100.run_cycles", 64'(n), 64'd100);
    sb_pop();

    // Asynchronous reset in the middle of a run
    restart("start4");
    bus.pc_valid = 1'b1;
    repeat (3) tick();
    check("mid.cycle_pre", 64'(bus.cycle_count), 64'd3);
    reset = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("async_rst.cycle", 64'(bus.cycle_count), 64'd0);
    check("async_rst.instr", 64'(bus.instr_count), 64'd0);
    tick();
    reset = 1'b1;
    bus.pc_valid = 1'b0;
    repeat (2) tick();
    check_outs("post_rst.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
